string1101_finder: RTL and testbench
====================================

STRING1101_FINDER -- requirements
Module: string1101_finder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all registers update on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-003 SHALL have port c0, input, 1 bit: current-state MSB for the combinational next-state core.
REQ-004 SHALL have port c1, input, 1 bit: current-state LSB for the combinational next-state core.
REQ-005 SHALL have port in, input, 1 bit: serial data bit.
REQ-006 SHALL have port in_valid, input, 1 bit: qualifies in for the internal tracker.
REQ-007 SHALL have port out, output, 1 bit: combinational detect flag of the core.
REQ-008 SHALL have port next0, output, 1 bit: combinational next-state MSB of the core.
REQ-009 SHALL have port next1, output, 1 bit: combinational next-state LSB of the core.
REQ-010 SHALL have port state_q, output, 2 bits: registered tracker state, {MSB,LSB}.
REQ-011 SHALL have port match, output, 1 bit: registered one-cycle pulse per detected "1101".
REQ-012 SHALL have port match_count, output, 8 bits: saturating count of detections.

Function
REQ-013 SHALL implement an overlapping Mealy "1101" detector with state code {c0,c1}: S0=00 idle, S1=01 seen "1", S2=10 seen "11", S3=11 seen "110".
REQ-014 SHALL compute {next0,next1} purely combinationally from c0, c1, in as follows: S0: in=0->00, in=1->01; S1: in=0->00, in=1->10; S2: in=0->11, in=1->10; S3: in=0->00, in=1->01.
REQ-015 SHALL drive out=1 only when c0=1, c1=1 and in=1; otherwise out=0.
REQ-016 SHALL make the core outputs independent of clk, rst and in_valid, with no internal storage.
REQ-017 SHALL feed the same next-state logic with state_q and in to form the tracker: on a clk edge with in_valid=1, state_q loads the next state; with in_valid=0, state_q holds.
REQ-018 SHALL register match=1 for exactly the cycle after an edge where in_valid=1, state_q=11 and in=1; otherwise match=0.
REQ-019 SHALL increment match_count by 1 on each edge that sets match, saturating at 255 with no wrap-around.
REQ-020 SHALL, after a detection, continue from S1 so that "1101101" yields two detections.

Reset
REQ-021 SHALL, on any clk edge with rst=1, set state_q=00, match=0 and match_count=0, overriding in_valid and in.
REQ-022 SHALL discard a partially matched sequence when rst is asserted mid-sequence; detection restarts from S0.
REQ-023 SHALL leave out, next0 and next1 unaffected by rst.

Configuration
REQ-024 SHALL, with macro STRING1101_COUNT_EN defined, include the match_count register per REQ-019.
REQ-025 SHALL, without STRING1101_COUNT_EN, omit the counter logic and tie match_count to constant 0; all other behaviour is unchanged.

Verification
REQ-026 SHALL sweep {c0,c1,in} from 000 to 111 at 10-time-unit steps and check (out,next0,next1) in order: 000,001,000,010,011,010,000,101.
REQ-027 SHALL apply rst for 1 cycle, then serial 1,1,0,1 with in_valid=1 -> state_q steps 01,10,11,01; match=1 only in the cycle after the 4th bit; match_count=1.
REQ-028 SHALL apply serial 1,1,0,1,1,0,1 -> two match pulses (after bits 4 and 7); match_count=2.
REQ-029 SHALL apply 1,1,0 followed by in_valid=0 for 3 cycles and then 1 -> state_q holds at 11 during the stall; match fires after the 1.
REQ-030 SHALL assert rst after 1,1,0 -> state_q=00; a following single 1 gives no match.
REQ-031 SHALL repeat "1101" 300 times with the macro defined -> match_count=255; without the macro -> match_count=0 throughout.

Source files
------------

// File: rtl/string1101_finder.sv
// Overlapping Mealy "1101" detector: combinational next-state core plus a registered tracker.
// Define STRING1101_COUNT_EN to include the saturating match counter.
module string1101_finder (
  input  logic       clk,
  input  logic       rst,
  input  logic       c0,
  input  logic       c1,
  input  logic       in,
  input  logic       in_valid,
  output logic       out,
  output logic       next0,
  output logic       next1,
  output logic [1:0] state_q,
  output logic       match,
  output logic [7:0] match_count
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  function automatic state_e nxt(input state_e s, input logic b);
    state_e n;
    n = S0;
    unique case (s)
      S0: n = b ? S1 : S0;
      S1: n = b ? S2 : S0;
      S2: n = b ? S2 : S3;
      S3: n = b ? S1 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

  state_e core_n;
  state_e st_q;
  state_e st_d;
  logic   match_q;
  logic   hit_d;

  assign core_n          = nxt(state_e'({c0, c1}), in);
  assign {next0, next1}  = core_n;
  assign out             = c0 & c1 & in;

  assign st_d  = in_valid ? nxt(st_q, in) : st_q;
  assign hit_d = in_valid & (st_q == S3) & in;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S0;
      match_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      match_q <= hit_d;
    end
  end

  assign state_q = st_q;
  assign match   = match_q;

`ifdef STRING1101_COUNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Saturate at 255 rather than wrapping.
  assign cnt_d = (hit_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`else
  assign match_count = 8'd0;
`endif

endmodule

// File: tb/tb_string1101_finder.sv
// Bench for string1101_finder: suffix-matching model over the bit history
// plus directed literal checks.
module tb_string1101_finder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       c0 = 1'b0;
  logic       c1 = 1'b0;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       out;
  logic       next0;
  logic       next1;
  logic [1:0] state_q;
  logic       match;
  logic [7:0] match_count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  bit h[$];
  int m_state = 0;
  bit m_match = 0;
  int m_cnt = 0;

  string1101_finder dut (
    .clk(clk), .rst(rst), .c0(c0), .c1(c1), .in(in),
    .in_valid(in_valid), .out(out), .next0(next0), .next1(next1),
    .state_q(state_q), .match(match), .match_count(match_count)
  );

  always #5 clk = ~clk;

  // Does the history end with the first k characters of "1101"?
  function automatic bit sfx(input bit q[$], input int k);
    bit p[4];
    p = '{1'b1, 1'b1, 1'b0, 1'b1};
    if (q.size() < k) return 1'b0;
    for (int j = 0; j < k; j++)
      if (q[q.size() - k + j] != p[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int longest(input bit q[$]);
    for (int k = 3; k > 0; k--)
      if (sfx(q, k)) return k;
    return 0;
  endfunction

  // State s means "the first s characters of 1101 have been seen".
  function automatic logic [2:0] core_ref(input int s, input bit b);
    bit p[4];
    bit w[$];
    p = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < s; i++) w.push_back(p[i]);
    w.push_back(b);
    return {sfx(w, 4), 2'(longest(w))};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      h.delete();
      m_match = 1'b0;
      m_cnt   = 0;
    end else begin
      m_match = 1'b0;
      if (in_valid) begin
        h.push_back(in);
        if (sfx(h, 4)) begin
          m_match = 1'b1;
`ifdef STRING1101_COUNT_EN
          if (m_cnt < 255) m_cnt++;
`endif
        end
        if (h.size() > 8) void'(h.pop_front());
      end
    end
    m_state = longest(h);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("core", {out, next0, next1}, core_ref(int'({c0, c1}), in));
      chk("state_q", state_q, m_state);
      chk("match", match, m_match);
      chk("match_count", match_count, m_cnt);
    end
  end

  task automatic step(input bit v, input bit b);
    @(negedge clk);
    #1;
    in_valid = v;
    in = b;
    c0 = 1'($urandom_range(0, 1));
    c1 = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    in = 1'b0;
    chk_en = 1'b1;
  endtask

  int exp_cnt;
  logic [2:0] sweep_exp [8];

  initial begin
    sweep_exp = '{3'b000, 3'b001, 3'b000, 3'b010,
                  3'b011, 3'b010, 3'b000, 3'b101};

    // Core sweep, before any reset: core has no storage.
    for (int i = 0; i < 8; i++) begin
      {c0, c1, in} = 3'(i);
      #4;
      chk($sformatf("sweep%0d", i), {out, next0, next1}, sweep_exp[i]);
      #6;
    end

    do_rst();
    chk("rst_state", state_q, 0);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_count, 0);

    step(1, 1); chk("a_s1", state_q, 1);  chk("a_m1", match, 0);
    step(1, 1); chk("a_s2", state_q, 2);  chk("a_m2", match, 0);
    step(1, 0); chk("a_s3", state_q, 3);  chk("a_m3", match, 0);
    step(1, 1); chk("a_s4", state_q, 1);  chk("a_m4", match, 1);
`ifdef STRING1101_COUNT_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    chk("a_cnt", match_count, exp_cnt);
    step(0, 1); chk("a_m5", match, 0);

    do_rst();
    step(1, 1); chk("b_m1", match, 0);
    step(1, 1); chk("b_m2", match, 0);
    step(1, 0); chk("b_m3", match, 0);
    step(1, 1); chk("b_m4", match, 1);
    step(1, 1); chk("b_m5", match, 0);
    step(1, 0); chk("b_m6", match, 0);
    step(1, 1); chk("b_m7", match, 1);
`ifdef STRING1101_COUNT_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    chk("b_cnt", match_count, exp_cnt);

    do_rst();
    step(1, 1);
    step(1, 1);
    step(1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      chk("c_hold", state_q, 3);
      chk("c_nomatch", match, 0);
    end
    step(1, 1); chk("c_match", match, 1);

    do_rst();
    step(1, 1);
    step(1, 1);
    step(1, 0);
    do_rst();
    chk("d_rst_state", state_q, 0);
    step(1, 1);
    chk("d_nomatch", match, 0);
    chk("d_state", state_q, 1);

    do_rst();
    for (int r = 0; r < 300; r++) begin
      step(1, 1);
      step(1, 1);
      step(1, 0);
      step(1, 1);
      chk("e_pulse", match, 1);
    end
`ifdef STRING1101_COUNT_EN
    exp_cnt = 255;
`else
    exp_cnt = 0;
`endif
    chk("e_sat", match_count, exp_cnt);

    step(0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
